// File: rtl/muldiv_sequencer_if.sv
// Handshake and control bundle between the main control FSM, the shared
// multiplier/divisor unit and the muldiv sequencer.
interface muldiv_sequencer_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic       cancel;
  logic       mult_fim;
  logic       div_fim;
  logic       div_zero;
  logic       req_ready;
  logic       busy;
  logic       mult_start;
  logic       div_start;
  logic       hi_sel;
  logic       lo_sel;
  logic       hi_write;
  logic       lo_write;
  logic       done;
  logic       exc_div0;
  logic       exc_illegal;
  logic       exc_timeout;

  // Requester / arithmetic-unit side.
  modport master (
    output req_valid, req_op, cancel, mult_fim, div_fim, div_zero,
    input  req_ready, busy, mult_start, div_start, hi_sel, lo_sel,
           hi_write, lo_write, done, exc_div0, exc_illegal, exc_timeout
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, cancel, mult_fim, div_fim, div_zero,
    output req_ready, busy, mult_start, div_start, hi_sel, lo_sel,
           hi_write, lo_write, done, exc_div0, exc_illegal, exc_timeout
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Muldiv sequencer: accepts one MULT/DIV request at a time, pulses the
// matching start line, waits for the unit's completion flag (bounded by
// TIMEOUT), then pulses the HI/LO writes. Reports div-by-zero, illegal op
// and timeout as one-cycle registered pulses; cancel aborts START/WAIT.
module muldiv_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                clock,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Last WAIT count before the op is abandoned.
  localparam logic [CNT_W-1:0] LastCount = CNT_W'(TIMEOUT - 1);

  state_t           stateReg;
  state_t           stateNext;
  logic             opReg;        // 0 = MULT, 1 = DIV
  logic             opNext;
  logic [CNT_W-1:0] countReg;
  logic [CNT_W-1:0] countNext;
  logic             excDiv0Reg;
  logic             excDiv0Next;
  logic             excIllegalReg;
  logic             excIllegalNext;
  logic             excTimeoutReg;
  logic             excTimeoutNext;
  logic             fimSel;

  // State, latched op, wait counter and exception pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg      <= ST_IDLE;
      opReg         <= 1'b0;
      countReg      <= {CNT_W{1'b0}};
      excDiv0Reg    <= 1'b0;
      excIllegalReg <= 1'b0;
      excTimeoutReg <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      opReg         <= opNext;
      countReg      <= countNext;
      excDiv0Reg    <= excDiv0Next;
      excIllegalReg <= excIllegalNext;
      excTimeoutReg <= excTimeoutNext;
    end
  end

  // Next-state, op latch, counter and exception decisions.
  always_comb begin
    stateNext      = stateReg;
    opNext         = opReg;
    countNext      = countReg;
    excDiv0Next    = 1'b0;
    excIllegalNext = 1'b0;
    excTimeoutNext = 1'b0;
    // Completion flag of the unit that was actually started.
    fimSel         = opReg ? bus.div_fim : bus.mult_fim;

    case (stateReg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_op[1]) begin
            excIllegalNext = 1'b1;
          end else begin
            opNext    = bus.req_op[0];
            stateNext = ST_START;
          end
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_START: begin
        // Any completion flag seen here belongs to an earlier op.
        countNext = {CNT_W{1'b0}};
        if (bus.cancel) begin
          stateNext = ST_IDLE;
        end else begin
          stateNext = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Priority: cancel, then completion, then timeout.
        if (bus.cancel) begin
          stateNext = ST_IDLE;
        end else if (fimSel) begin
          if (opReg && bus.div_zero) begin
            stateNext   = ST_IDLE;
            excDiv0Next = 1'b1;
          end else begin
            stateNext = ST_WRITE;
          end
        end else if (countReg == LastCount) begin
          stateNext      = ST_IDLE;
          excTimeoutNext = 1'b1;
        end else begin
          countNext = countReg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_WRITE: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from registered state and op.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.hi_write   = 1'b0;
    bus.lo_write   = 1'b0;
    bus.done       = 1'b0;
    bus.hi_sel     = opReg;
    bus.lo_sel     = opReg;
    case (stateReg)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
      end
      ST_START: begin
        bus.busy       = 1'b1;
        bus.mult_start = ~opReg;
        bus.div_start  = opReg;
      end
      ST_WAIT: begin
        bus.busy = 1'b1;
      end
      ST_WRITE: begin
        bus.busy     = 1'b1;
        bus.hi_write = 1'b1;
        bus.lo_write = 1'b1;
        bus.done     = 1'b1;
      end
      default: begin
        bus.req_ready = 1'b0;
      end
    endcase
  end

  // Exception pulses come straight from their registers.
  always_comb begin
    bus.exc_div0    = excDiv0Reg;
    bus.exc_illegal = excIllegalReg;
    bus.exc_timeout = excTimeoutReg;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (TIMEOUT=8). Inputs change and outputs
// are checked on the falling clock edge. Output vector field order:
// {req_ready, busy, mult_start, div_start, hi_sel, lo_sel,
//  hi_write, lo_write, done, exc_div0, exc_illegal, exc_timeout}
module tb_muldiv_sequencer;

  logic clock;
  logic reset;
  int   nCmp;
  int   nErr;

  muldiv_sequencer_if busIf ();

  muldiv_sequencer #(
    .TIMEOUT (8),
    .CNT_W   (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (busIf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [11:0] expv);
    logic [11:0] obs;
    obs = {busIf.req_ready, busIf.busy, busIf.mult_start, busIf.div_start,
           busIf.hi_sel, busIf.lo_sel, busIf.hi_write, busIf.lo_write,
           busIf.done, busIf.exc_div0, busIf.exc_illegal, busIf.exc_timeout};
    nCmp++;
    assert (obs === expv) else begin
      nErr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic request(input logic [1:0] op);
    busIf.req_valid = 1'b1;
    busIf.req_op    = op;
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nCmp = 0;
    nErr = 0;
    reset = 1'b1;
    busIf.req_valid = 1'b0;
    busIf.req_op    = 2'b00;
    busIf.cancel    = 1'b0;
    busIf.mult_fim  = 1'b0;
    busIf.div_fim   = 1'b0;
    busIf.div_zero  = 1'b0;

    step(); chk("reset_held", 12'b1000_0000_0000);
    reset = 1'b0;
    step(); chk("idle", 12'b1000_0000_0000);

    // T1: MULT completing 5 cycles after start.
    request(2'b00);
    step(); chk("t1_start", 12'b0110_0000_0000);
    busIf.req_valid = 1'b0;
    step(); chk("t1_wait1", 12'b0100_0000_0000);
    for (int i = 0; i < 3; i++) begin
      step(); chk("t1_wait", 12'b0100_0000_0000);
    end
    step(); chk("t1_wait5", 12'b0100_0000_0000);
    busIf.mult_fim = 1'b1;
    step(); chk("t1_write", 12'b0100_0011_1000);
    busIf.mult_fim = 1'b0;
    step(); chk("t1_idle", 12'b1000_0000_0000);

    // T2: DIV with divide-by-zero; flag already high in START is stale.
    request(2'b01);
    step(); chk("t2_start", 12'b0101_1100_0000);
    busIf.req_valid = 1'b0;
    busIf.div_fim   = 1'b1;
    busIf.div_zero  = 1'b1;
    step(); chk("t2_wait_stale", 12'b0100_1100_0000);
    step(); chk("t2_div0", 12'b1000_1100_0100);
    busIf.div_fim  = 1'b0;
    busIf.div_zero = 1'b0;
    step(); chk("t2_after", 12'b1000_1100_0000);

    // T3: DIV never completes -> timeout after 8 WAIT cycles.
    request(2'b01);
    step(); chk("t3_start", 12'b0101_1100_0000);
    busIf.req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); chk("t3_wait", 12'b0100_1100_0000);
    end
    step(); chk("t3_timeout", 12'b1000_1100_0001);
    step(); chk("t3_after", 12'b1000_1100_0000);

    // T4: cancel beats fim, then MULT and back-to-back DIV complete.
    request(2'b00);
    step(); chk("t4_start", 12'b0110_0000_0000);
    busIf.req_valid = 1'b0;
    step(); chk("t4_wait", 12'b0100_0000_0000);
    busIf.cancel   = 1'b1;
    busIf.mult_fim = 1'b1;
    step(); chk("t4_cancel", 12'b1000_0000_0000);
    busIf.cancel   = 1'b0;
    busIf.mult_fim = 1'b0;
    request(2'b00);
    step(); chk("t4_start2", 12'b0110_0000_0000);
    busIf.req_valid = 1'b0;
    step(); chk("t4_wait2", 12'b0100_0000_0000);
    busIf.mult_fim = 1'b1;
    step(); chk("t4_write2", 12'b0100_0011_1000);
    busIf.mult_fim = 1'b0;
    request(2'b01);
    step(); chk("t4_b2b_idle", 12'b1000_0000_0000);
    step(); chk("t4_b2b_start", 12'b0101_1100_0000);
    busIf.req_valid = 1'b0;
    step(); chk("t4_b2b_wait", 12'b0100_1100_0000);
    busIf.div_fim = 1'b1;
    step(); chk("t4_div_write", 12'b0100_1111_1000);
    busIf.div_fim = 1'b0;
    step(); chk("t4_div_idle", 12'b1000_1100_0000);

    // T5: illegal ops pulse exc_illegal only.
    request(2'b10);
    step(); chk("t5_illegal10", 12'b1000_1100_0010);
    busIf.req_valid = 1'b0;
    step(); chk("t5_after10", 12'b1000_1100_0000);
    request(2'b11);
    step(); chk("t5_illegal11", 12'b1000_1100_0010);
    busIf.req_valid = 1'b0;
    step(); chk("t5_after11", 12'b1000_1100_0000);

    // Async reset in WAIT, between clock edges.
    request(2'b01);
    step(); chk("rst_start", 12'b0101_1100_0000);
    busIf.req_valid = 1'b0;
    step(); chk("rst_wait", 12'b0100_1100_0000);
    #2;
    reset         = 1'b1;
    busIf.div_fim = 1'b1;
    #1;
    chk("rst_async", 12'b1000_0000_0000);
    step(); chk("rst_held2", 12'b1000_0000_0000);
    reset = 1'b0;
    step(); chk("rst_release", 12'b1000_0000_0000);
    busIf.div_fim = 1'b0;
    step(); chk("rst_idle", 12'b1000_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
